receiver: RTL
=============

# receiver

Serial-to-parallel receive stage paired with the 40-bit frame sender. It consumes the one-wire serial stream that the sender produces: an idle-low line, a single `1` start bit, then 40 data bits LSB first, with each bit one clock period long. It reassembles each frame into a 40-bit word and presents it downstream through a valid/ready holding register, with overrun signalling.

## Interface
- `DATA_WIDTH`, 40, payload bits per frame (start bit excluded).
- `clk`  input  1  sole clock; all state updates on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sin`  input  1  serial in; synchronous to `clk`, launched by the sender on negedge, sampled here on posedge.
- `out_data`  output  DATA_WIDTH  received word, LSB = first data bit on the line.
- `out_valid`  output  1  `out_data` holds an unconsumed word.
- `out_ready`  input  1  downstream accepts the word when high with `out_valid`.
- `busy`  output  1  a frame is being received (state RECV).
- `overrun`  output  1  one-cycle pulse: a frame completed while the holding register was full; that frame is dropped.

## Operation
- Two-state FSM:
  - IDLE: on a posedge with `sin`=1, go to RECV and clear the bit counter to 0. The start bit is not stored.
  - RECV: each posedge, shift `sin` into the MSB of the shift register, shifting right, and increment the counter.
  - When the counter reaches DATA_WIDTH−1 and that bit has been sampled, return to IDLE.
- Frame complete (last data bit sampled):
  - If the holding register is empty, or `out_valid && out_ready` in the same cycle, load the shift register into `out_data` and set `out_valid` next cycle.
  - Otherwise drop the frame: `out_data` is unchanged and `overrun` pulses for one cycle.
- Handshake:
  - `out_valid` clears on the cycle after `out_valid && out_ready`, unless a new word loads in that same cycle, in which case it stays high with the new data.
  - `out_data` is stable while `out_valid` is high and not accepted.
- `sin`=0 in IDLE is idle and is ignored. Data bits in RECV are taken verbatim; no framing check is made on their values.
- Reset values: `out_valid`=0, `busy`=0, `overrun`=0, `out_data`=0, state=IDLE, counter=0, shift register=0.
- Reset asserted mid-frame aborts the frame with no output. After release, the block waits for a fresh start bit. Line bits still in flight are treated as idle or start bits as they arrive.

## Timing
- Start bit sampled at posedge k, so `busy`=1 from k+1.
- Data bit i is sampled at posedge k+1+i, for i=0..39.
- `out_valid` rises, and `overrun` pulses, at k+41. `busy`=0 from k+41.
- Back-to-back frames: a start bit sampled at k+41 is accepted, with no idle gap required.
- Latency from the last data bit on the line to `out_valid` is one cycle.
- Counter is 6 bits and never wraps, since it resets at every start bit.

## Structure
- Shared package `nextasic_pkg` holds:
  - `FRAME_DATA_BITS` = 40 and `FRAME_START_BIT` = 1'b1, shared with the sender.
  - The receiver state typedef, `RX_IDLE` / `RX_RECV`.
- No sub-module is warranted. The FSM, counter, shift register and holding register are inline.

## Test plan
- Single frame 40'hD999999991 (start bit, then LSB-first bits), `out_ready`=1 → `out_valid` pulses one cycle at k+41 with `out_data`=40'hD999999991; `busy` is high for exactly 40 cycles.
- Two back-to-back frames 40'h0000000001 then 40'h8000000000, second start bit at k+41, `out_ready`=1 → both words delivered in order, 41 cycles apart, no `overrun`.
- `out_ready`=0, two frames 40'h123456789A then 40'hFFFFFFFFFF → `out_data` stays 40'h123456789A; `overrun` pulses once at the second completion; raising `out_ready` consumes the word and `out_valid` drops next cycle.
- `out_ready` raised in the exact completion cycle of a second frame while the first is held → first word accepted, second word loaded, `out_valid` stays high with the second word, no `overrun`.
- `rst_n` pulsed low after 20 data bits → `busy`=0 and `out_valid`=0 immediately; no word is emitted for the aborted frame; the next full frame 40'h0F0F0F0F0F is received correctly.
- Idle line held at 0 for 100 cycles → `busy`, `out_valid` and `overrun` all remain 0.

Source files
------------

// File: rtl/nextasic_pkg.sv
// Definitions shared by the 40-bit frame sender and receiver: frame geometry,
// start-bit polarity and the receiver state encoding.
package nextasic_pkg;

    localparam int   FRAME_DATA_BITS = 40;
    localparam logic FRAME_START_BIT = 1'b1;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/receiver_if.sv
// Downstream side of the receiver: the valid/ready word port plus status flags.
// The receiver drives through master; the consumer connects through slave.
interface receiver_if #(
    parameter int DATA_WIDTH = 40
) ();

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  overrun;

    modport master (
        output out_data,
        output out_valid,
        output busy,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  busy,
        input  overrun,
        output out_ready
    );

endinterface

// File: rtl/receiver.sv
// Serial-to-parallel receiver: waits for a start bit, shifts in DATA_WIDTH
// LSB-first bits, then offers the word through a valid/ready holding register.
module receiver
    import nextasic_pkg::*;
#(
    parameter int DATA_WIDTH = FRAME_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sin,
    receiver_if.master rx
);

    localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);

    rx_state_t             state_reg;
    logic [5:0]            cnt_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg;
    logic                  overrun_reg;
    logic                  frame_done;
    logic                  load_ok;

    // Shifting right with the new bit at the MSB leaves the first bit at the LSB.
    assign shift_next = {sin, shift_reg[DATA_WIDTH-1:1]};
    assign frame_done = (state_reg == RX_RECV) && (cnt_reg == LAST_BIT);
    // A completed frame may load when the holder is empty or being drained now.
    assign load_ok    = !valid_reg || rx.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;

            case (state_reg)
                RX_IDLE: begin
                    if (sin == FRAME_START_BIT) begin
                        state_reg <= RX_RECV;
                        cnt_reg   <= '0;
                    end
                end
                RX_RECV: begin
                    shift_reg <= shift_next;
                    cnt_reg   <= cnt_reg + 6'd1;
                    if (frame_done) begin
                        state_reg <= RX_IDLE;
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase

            if (frame_done && load_ok) begin
                data_reg  <= shift_next;
                valid_reg <= 1'b1;
            end else begin
                if (valid_reg && rx.out_ready) begin
                    valid_reg <= 1'b0;
                end
                if (frame_done) begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    assign rx.out_data  = data_reg;
    assign rx.out_valid = valid_reg;
    assign rx.busy      = (state_reg == RX_RECV);
    assign rx.overrun   = overrun_reg;

endmodule
